// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter/rotator: repeats one single-bit ALU shift per clock
// until the requested amount (0..31) has been applied to the accumulator.

module ALU (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cin,
   input  logic [3:0]  operation,
   output logic [31:0] result,
   output logic        C,
   output logic        N,
   output logic        V,
   output logic        Z
);
   logic [32:0] sum;

   always_comb begin
      sum    = 33'd0;
      result = 32'd0;
      C      = 1'b0;
      V      = 1'b0;
      case (operation)
         4'd0: begin
            sum    = {1'b0, A} + {1'b0, B};
            result = sum[31:0];
            C      = sum[32];
            V      = (A[31] == B[31]) && (result[31] != A[31]);
         end
         4'd1: begin
            sum    = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
            result = sum[31:0];
            C      = sum[32];
            V      = (A[31] == B[31]) && (result[31] != A[31]);
         end
         4'd2: begin
            sum    = {1'b0, A} - {1'b0, B};
            result = sum[31:0];
            C      = sum[32];
            V      = (A[31] != B[31]) && (result[31] != A[31]);
         end
         4'd3:  result = A & B;
         4'd4:  result = A | B;
         4'd5:  result = A ^ B;
         4'd6:  result = ~A;
         4'd7:  result = A;
         4'd8:  result = B;
         // Single-bit shifts/rotates; C is the bit moved out.
         4'd9:  begin result = {A[30:0], 1'b0};  C = A[31]; end
         4'd10: begin result = {1'b0, A[31:1]};  C = A[0];  end
         4'd11: begin result = {A[30:0], A[31]}; C = A[31]; end
         4'd12: begin result = {A[0], A[31:1]};  C = A[0];  end
         default: result = 32'd0;
      endcase
   end

   assign N = result[31];
   assign Z = (result == 32'd0);
endmodule

module alu_shift_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand,
   input  logic [4:0]  amount,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        carry,
   output logic        neg,
   output logic        zero
);
   localparam int WIDTH = 32;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d;

   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_op;
   logic             alu_c_unused, alu_n_unused, alu_v_unused, alu_z_unused;

   // op 00/01/10/11 maps onto ALU codes 9/10/11/12
   assign alu_op = 4'd9 + {2'b00, op_q};

   ALU u_alu (
      .A         (acc_q),
      .B         (32'd0),
      .Cin       (1'b0),
      .operation (alu_op),
      .result    (alu_result),
      .C         (alu_c_unused),
      .N         (alu_n_unused),
      .V         (alu_v_unused),
      .Z         (alu_z_unused)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               acc_d = operand;
               cnt_d = amount;
               if (amount != 5'd0) begin
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
                  carry_d = 1'b0;
               end
            end
         end
         SHIFT: begin
            acc_d   = alu_result;
            // Left-moving ops (LSL, RL) have op[0] = 0 and lose the MSB.
            carry_d = op_q[0] ? acc_q[0] : acc_q[WIDTH-1];
            cnt_d   = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         carry_q <= carry_d;
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign result = acc_q;
   assign carry  = carry_q;
   assign neg    = acc_q[WIDTH-1];
   assign zero   = (acc_q == '0);
endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller that performs shifts and rotates by 0–31 bit positions using the single-bit shift/rotate operations of the `ALU` module. It instantiates one `ALU` and feeds the ALU result back into an internal accumulator once per clock until the requested amount is exhausted. It sits between the instruction decode/execute control and the ALU, and serves shifter-type instructions that need a variable shift amount.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Fixed at 32 to match `ALU`; not overridable.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset. This is decided and must not change.
- `start`, input, 1: request strobe. Sampled only in `IDLE`.
- `op`, input, 2: operation select. 00 = LSL, 01 = LSR, 10 = RL, 11 = RR.
- `operand`, input, 32: value to shift. Captured on the accepted `start`.
- `amount`, input, 5: shift count, 0–31. Captured on the accepted `start`.
- `busy`, output, 1: high while in `SHIFT`.
- `done`, output, 1: one-cycle completion pulse.
- `result`, output, 32: final value. Held stable until the next accepted `start`.
- `carry`, output, 1: last bit shifted or rotated out. 0 when `amount` = 0.
- `neg`, output, 1: `result[31]`.
- `zero`, output, 1: high when `result` = 0.

## Operation
- **ALU wiring:**
  - `A` = accumulator, `B` = 0, `Cin` = 0.
  - `operation` = ALU code 9/10/11/12 (LSL/LSR/RL/RR) for `op` 00/01/10/11.
  - The sequencer ignores the ALU's C/N/V/Z outputs and computes its own flags.
- **FSM states:** `IDLE`, `SHIFT`, `DONE`.
- **IDLE:**
  - On `start` = 1, latch `op`, load the accumulator with `operand`, and load the counter with `amount`.
  - If `amount` != 0, go to `SHIFT`. If `amount` = 0, go to `DONE` and set `carry` to 0.
- **SHIFT:** each cycle:
  - accumulator <= ALU result.
  - `carry` <= outgoing bit: `acc[31]` for LSL/RL, `acc[0]` for LSR/RR.
  - counter <= counter − 1.
  - When the counter equals 1, go to `DONE`.
- **DONE:** `done` = 1 for exactly one cycle, then return unconditionally to `IDLE`.
- **Outputs:**
  - `result` mirrors the accumulator.
  - `neg` and `zero` are derived combinationally from `result`, so they are valid whenever `done` is high and afterwards.
  - Mid-operation values are visible but not meaningful.
- **Counter width:** 5 bits; it never wraps, because exit happens at 1.
- **`start` outside `IDLE`:** ignored in `SHIFT` and `DONE`. It is neither queued nor does it abort.
- **Input stability:** `op`, `operand` and `amount` changes after acceptance have no effect.
- **Reset** (asynchronous, any state, including mid-`SHIFT`):
  - state = `IDLE`; accumulator, `carry` and counter = 0.
  - Outputs become `busy` = 0, `done` = 0, `result` = 0, `carry` = 0, `neg` = 0, `zero` = 1.
- **After reset release:** the first rising edge with `start` = 1 is accepted normally.

## Timing
- `start` is accepted on edge k.
- `amount` = n > 0:
  - `busy` is high in cycles k+1 … k+n.
  - `done` is high in cycle k+n+1; `result` is final from that cycle.
- `amount` = 0: `done` is high in cycle k+1 and `busy` never asserts.
- Next acceptance: earliest at edge k+n+2 (k+2 for `amount` = 0), i.e. the first edge where the state is `IDLE`.
- Throughput: one request per n+2 cycles.
- The ALU path is combinational within one cycle: accumulator → ALU → accumulator.

## Test plan
1. LSL, `operand` = 0x0000_0001, `amount` = 4 → `busy` high for 4 cycles, then `done`; `result` = 0x0000_0010, `carry` = 0, `neg` = 0, `zero` = 0.
2. RR, `operand` = 0x0000_0001, `amount` = 1 → `done` at k+2; `result` = 0x8000_0000, `carry` = 1, `neg` = 1.
3. LSR, `operand` = 0x8000_0001, `amount` = 31 → `done` at k+32; `result` = 0x0000_0001, `carry` = 0. Check that the counter does not wrap.
4. RL, `operand` = 0xF000_0000, `amount` = 8 → `result` = 0x0000_00F0, `carry` = 0. Then with `amount` = 0 and `operand` = 0: `done` at k+1, `result` = 0, `zero` = 1, `carry` = 0, and `busy` never high.
5. LSL, `operand` = 0x1, `amount` = 10:
   - Pulse `start` with different inputs during `SHIFT`; it is ignored and the result is still 0x400.
   - Assert `rst_n` = 0 mid-operation (3rd `SHIFT` cycle); outputs clear immediately to the reset values.
   - After release, a new LSL 0x3 by 2 yields 0xC.
6. Back-to-back: hold `start` high continuously → accepts occur only in `IDLE`, spaced n+2 cycles apart, with exactly one `done` per accept.
